// File: rtl/ks_adder_pipe_pkg.sv
// Shared types and elaboration-time helpers for the pipelined Kogge-Stone adder.
// A prefix node carries a (generate, propagate) pair; pg_combine is the tree operator.
package ks_adder_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int num_levels(input int width);
        return clog2(width);
    endfunction

    // Input register plus one register per group of prefix levels.
    function automatic int lat(input int width, input int levels_per_stage);
        return 1 + (num_levels(width) + levels_per_stage - 1) / levels_per_stage;
    endfunction

    function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
        pg_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/ks_adder_pipe_level.sv
// One combinational Kogge-Stone prefix level: each node merges with the node DIST below it.
// Nodes with no partner at that distance pass straight through.
module ks_prefix_level
    import ks_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIST  = 1
) (
    input  pg_t [WIDTH-1:0] pg_i,
    output pg_t [WIDTH-1:0] pg_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_node
        if (i >= DIST) begin : g_merge
            assign pg_o[i] = pg_combine(pg_i[i], pg_i[i-DIST]);
        end else begin : g_pass
            assign pg_o[i] = pg_i[i];
        end
    end

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with a global valid/ready stall.
// Carry-in occupies tree position 0, so tree position i yields the carry into sum bit i.
module ks_adder_pipe
    import ks_adder_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int LEVELS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int NL = num_levels(WIDTH);
    localparam int NS = (NL + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

    logic             en;
    logic             accept;
    logic [WIDTH-1:0] bx;
    logic             c0;
    logic [WIDTH-1:0] in_p;
    logic [WIDTH-1:0] in_g;
    pg_t  [WIDTH-1:0] pg_in;

    pg_t  [WIDTH-1:0] st_pg_q [NS];
    logic [WIDTH-1:0] st_p_q  [NS];
    logic [NS-1:0]    st_gm_q;
    logic [NS-1:0]    st_vld_q;

    pg_t  [WIDTH-1:0] lvl_in  [NL];
    pg_t  [WIDTH-1:0] lvl_out [NL];

    logic [WIDTH-1:0] c_vec;
    logic [WIDTH-1:0] tree_p_unused;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;
    logic             zero_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_cout_q;
    logic             out_ovf_q;
    logic             out_zero_q;

    assign en       = !out_valid_q | out_ready;
    assign in_ready = en & !rst;
    assign accept   = in_valid & in_ready;

    always_comb begin
        bx       = in_sub ? ~in_b : in_b;
        c0       = in_sub | in_cin;
        in_p     = in_a ^ bx;
        in_g     = in_a & bx;
        pg_in[0] = '{g: c0, p: 1'b0};
        for (int j = 1; j < WIDTH; j++) begin
            pg_in[j] = '{g: in_g[j-1], p: in_p[j-1]};
        end
    end

    // Prefix levels; a group of LEVELS_PER_STAGE levels starts from a stage register.
    for (genvar l = 0; l < NL; l++) begin : g_lvl
        if (l % LEVELS_PER_STAGE == 0) begin : g_from_reg
            assign lvl_in[l] = st_pg_q[l / LEVELS_PER_STAGE];
        end else begin : g_chain
            assign lvl_in[l] = lvl_out[l-1];
        end

        ks_prefix_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << l)
        ) u_level (
            .pg_i (lvl_in[l]),
            .pg_o (lvl_out[l])
        );
    end

    // Final group: group-propagate bits are all zero here (position 0 has p=0).
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            c_vec[i]         = lvl_out[NL-1][i].g;
            tree_p_unused[i] = lvl_out[NL-1][i].p;
        end
        sum_d  = st_p_q[NS-1] ^ c_vec;
        cout_d = st_gm_q[NS-1] | (st_p_q[NS-1][WIDTH-1] & c_vec[WIDTH-1]);
        ovf_d  = c_vec[WIDTH-1] ^ cout_d;
        zero_d = ~|sum_d;
    end

    // Stage data registers: loaded on every advance, bubbles included.
    always_ff @(posedge clk) begin
        if (en) begin
            st_pg_q[0] <= pg_in;
            st_p_q[0]  <= in_p;
            st_gm_q[0] <= in_g[WIDTH-1];
            for (int k = 1; k < NS; k++) begin
                st_pg_q[k] <= lvl_out[k*LEVELS_PER_STAGE-1];
                st_p_q[k]  <= st_p_q[k-1];
                st_gm_q[k] <= st_gm_q[k-1];
            end
        end
    end

    // Valid chain and output register; output data changes only on a real beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_vld_q    <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_zero_q  <= 1'b0;
        end else if (en) begin
            st_vld_q[0] <= accept;
            for (int k = 1; k < NS; k++) begin
                st_vld_q[k] <= st_vld_q[k-1];
            end
            out_valid_q <= st_vld_q[NS-1];
            if (st_vld_q[NS-1]) begin
                out_sum_q  <= sum_d;
                out_cout_q <= cout_d;
                out_ovf_q  <= ovf_d;
                out_zero_q <= zero_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Bench for ks_adder_pipe: a 16-bit/2-levels-per-stage instance and a 4-bit/1-level instance,
// checked against an arithmetic reference model through an in-order scoreboard.
module tb_ks_adder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_in_valid, a_in_ready, a_in_cin, a_in_sub;
    logic        a_out_valid, a_out_ready, a_out_cout, a_out_ovf, a_out_zero;
    logic [15:0] a_in_a, a_in_b, a_out_sum;

    logic        b_in_valid, b_in_ready, b_in_cin, b_in_sub;
    logic        b_out_valid, b_out_ready, b_out_cout, b_out_ovf, b_out_zero;
    logic [3:0]  b_in_a, b_in_b, b_out_sum;

    ks_adder_pipe #(.WIDTH(16), .LEVELS_PER_STAGE(2)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_a      (a_in_a),
        .in_b      (a_in_b),
        .in_cin    (a_in_cin),
        .in_sub    (a_in_sub),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_sum   (a_out_sum),
        .out_cout  (a_out_cout),
        .out_ovf   (a_out_ovf),
        .out_zero  (a_out_zero)
    );

    ks_adder_pipe #(.WIDTH(4), .LEVELS_PER_STAGE(1)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_a      (b_in_a),
        .in_b      (b_in_b),
        .in_cin    (b_in_cin),
        .in_sub    (b_in_sub),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_sum   (b_out_sum),
        .out_cout  (b_out_cout),
        .out_ovf   (b_out_ovf),
        .out_zero  (b_out_zero)
    );

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        int          cyc;
        bit          has_k;
        logic [18:0] k;
    } beat_t;

    beat_t       qa[$];
    beat_t       qb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          lat_chk_a = 1'b1;
    bit          last_acc_a = 1'b1;
    bit          next_has_k = 1'b0;
    logic [18:0] next_k = '0;
    logic [15:0] held_sum;

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        exp_t   e;
        longint mask, half, av, bv, c0, full, sa, sb, s;
        mask   = (longint'(1) << w) - 1;
        half   = longint'(1) << (w - 1);
        av     = longint'(a) & mask;
        bv     = sub ? (~longint'(b) & mask) : (longint'(b) & mask);
        c0     = (sub || cin) ? 1 : 0;
        full   = av + bv + c0;
        sa     = (av >= half) ? av - 2 * half : av;
        sb     = (bv >= half) ? bv - 2 * half : bv;
        s      = sa + sb + c0;
        e.sum  = 16'(full & mask);
        e.cout = ((full >> w) & 1) != 0;
        e.ovf  = (s >= half) || (s < -half);
        e.zero = (full & mask) == 0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes away from the edge, score, then advance.
    task automatic tick();
        bit    acc_a, con_a, acc_b, con_b;
        beat_t e;
        exp_t  x;
        #2;
        acc_a = a_in_valid && a_in_ready;
        con_a = a_out_valid && a_out_ready;
        acc_b = b_in_valid && b_in_ready;
        con_b = b_out_valid && b_out_ready;
        if (con_a) begin
            check("a_beat_expected", 32'(qa.size() > 0), 32'd1);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                x = model(16, e.a, e.b, e.cin, e.sub);
                check("a_result", {a_out_sum, a_out_cout, a_out_ovf, a_out_zero},
                      {x.sum, x.cout, x.ovf, x.zero});
                if (e.has_k)
                    check("a_directed", {a_out_sum, a_out_cout, a_out_ovf, a_out_zero}, e.k);
                if (lat_chk_a)
                    check("a_latency", cyc - e.cyc, 32'd3);
            end
        end
        if (acc_a) begin
            e = '{a: a_in_a, b: a_in_b, cin: a_in_cin, sub: a_in_sub, cyc: cyc,
                  has_k: next_has_k, k: next_k};
            qa.push_back(e);
        end
        if (con_b) begin
            check("b_beat_expected", 32'(qb.size() > 0), 32'd1);
            if (qb.size() > 0) begin
                e = qb.pop_front();
                x = model(4, e.a, e.b, e.cin, e.sub);
                check("b_result", {b_out_sum, b_out_cout, b_out_ovf, b_out_zero},
                      {x.sum[3:0], x.cout, x.ovf, x.zero});
                check("b_latency", cyc - e.cyc, 32'd3);
                if (!e.sub && !e.cin)
                    check("b_plain_add", {b_out_cout, b_out_sum},
                          32'(e.a[3:0]) + 32'(e.b[3:0]));
            end
        end
        if (acc_b) begin
            e = '{a: {12'h0, b_in_a}, b: {12'h0, b_in_b}, cin: b_in_cin, sub: b_in_sub,
                  cyc: cyc, has_k: 1'b0, k: '0};
            qb.push_back(e);
        end
        last_acc_a = acc_a;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send_a(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, input logic [18:0] k);
        a_in_valid = 1'b1;
        a_in_a = a; a_in_b = b; a_in_cin = cin; a_in_sub = sub;
        next_has_k = 1'b1;
        next_k = k;
        tick();
        next_has_k = 1'b0;
    endtask

    task automatic rand_a();
        a_in_a   = 16'($urandom);
        a_in_b   = 16'($urandom);
        a_in_cin = 1'($urandom);
        a_in_sub = 1'($urandom);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && (qa.size() > 0 || qb.size() > 0); i++) tick();
        check(tag, qa.size() + qb.size(), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_a = '0; a_in_b = '0; a_in_cin = 1'b0; a_in_sub = 1'b0;
        a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_a = '0; b_in_b = '0; b_in_cin = 1'b0; b_in_sub = 1'b0;
        b_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("a_reset_outputs", {a_out_valid, a_out_sum, a_out_cout, a_out_ovf, a_out_zero}, 32'd0);
        check("b_reset_outputs", {b_out_valid, b_out_sum, b_out_cout, b_out_ovf, b_out_zero}, 32'd0);
        rst = 1'b0;
        #1;
        check("a_in_ready_after_reset", 32'(a_in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed corner cases.
        send_a(16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1});
        send_a(16'h7FFF, 16'h0001, 1'b1, 1'b0, {16'h8001, 1'b0, 1'b1, 1'b0});
        send_a(16'h0005, 16'h0007, 1'b0, 1'b1, {16'hFFFE, 1'b0, 1'b0, 1'b0});
        a_in_valid = 1'b0;
        drain("a_drain_directed");

        // 100 back-to-back random beats.
        a_in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rand_a();
            check("a_in_ready_stream", 32'(a_in_ready), 32'd1);
            tick();
        end
        a_in_valid = 1'b0;
        drain("a_drain_stream");

        // Backpressure: consumer stalls for 5 cycles mid-stream.
        lat_chk_a = 1'b0;
        last_acc_a = 1'b1;
        a_in_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (last_acc_a) rand_a();
            a_out_ready = !(i >= 10 && i < 15);
            #0;
            if (i == 10) held_sum = a_out_sum;
            if (i >= 10 && i < 15) begin
                check("a_stall_in_ready", 32'(a_in_ready), 32'd0);
                check("a_stall_out_valid", 32'(a_out_valid), 32'd1);
                check("a_stall_sum_stable", 32'(a_out_sum), 32'(held_sum));
            end
            tick();
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        drain("a_drain_backpressure");

        // Reset with three beats in flight.
        lat_chk_a = 1'b1;
        a_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_a();
            tick();
        end
        a_in_valid = 1'b0;
        check("a_valid_before_reset", 32'(a_out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("a_valid_in_reset", 32'(a_out_valid), 32'd0);
        qa.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        a_in_valid = 1'b1;
        rand_a();
        tick();
        a_in_valid = 1'b0;
        drain("a_drain_after_reset");

        // Exhaustive 4-bit sweep on the narrow instance.
        b_in_valid = 1'b1;
        for (int idx = 0; idx < 1024; idx++) begin
            logic [9:0] v;
            v = 10'(idx);
            b_in_a   = v[3:0];
            b_in_b   = v[7:4];
            b_in_cin = v[8];
            b_in_sub = v[9];
            tick();
        end
        b_in_valid = 1'b0;
        drain("b_drain_exhaustive");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ks_adder_pipe.md
Name: ks_adder_pipe

Overview:
- Parametrised, pipelined Kogge-Stone adder/subtractor; next generation of the team's fixed 4-bit combinational Kogge-Stone adder.
- Adds WIDTH-bit operands with carry-in and an add/sub mode.
- Registers the prefix tree every LEVELS_PER_STAGE levels and wraps the pipeline in valid/ready handshakes.
- Sits between an operand source (sequencer/ALU front end) and a result consumer that may apply backpressure.

Parameters:
WIDTH, 16, operand/result width; power of two, 4..64.
LEVELS_PER_STAGE, 2, prefix levels per pipeline register; 1..log2(WIDTH).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  operand beat valid.
in_ready  output  1  block accepts a beat this cycle.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_cin  input  1  carry-in; ignored when in_sub=1.
in_sub  input  1  1 = A-B (B inverted, carry-in forced 1).
out_valid  output  1  result beat valid.
out_ready  input  1  consumer accepts result.
out_sum  output  WIDTH  result.
out_cout  output  1  carry out; in subtract mode 1 = no borrow.
out_ovf  output  1  signed overflow: carry into MSB XOR carry out.
out_zero  output  1  out_sum == 0.

Behaviour:
- One clock; reset asynchronous, active-high.
- Reset: all stage valid bits, out_valid, out_sum, out_cout, out_ovf and out_zero = 0.
- Stage 0 (input register) captures Bx = in_sub ? ~in_b : in_b, c0 = in_sub | in_cin, p = A^Bx, g = A&Bx.
- c0 is folded in as generate bit g[-1], so carry-in costs no extra level.
- Prefix tree: log2(WIDTH) Kogge-Stone levels, span 1,2,4,...
  - Node: G = Gh | (Ph & Gl); P = Ph & Pl.
  - Positions with no partner at distance d pass through unchanged.
- A pipeline register follows every LEVELS_PER_STAGE levels. The final stage computes sum = p ^ carries, cout, ovf and zero, all registered.
- Latency LAT = 1 + ceil(log2(WIDTH)/LEVELS_PER_STAGE) cycles from accept to out_valid (default 3). p travels with the tree stages.
- Throughput: one beat per cycle when out_ready is held 1.
- Flow control is global: en = !out_valid | out_ready.
  - in_ready = en.
  - All stages, including valid bits, advance only when en = 1.
  - Beat accepted iff in_valid & in_ready.
- Bubbles are carried (valid=0 stages); there is no bubble collapse.
- Stall (out_valid=1, out_ready=0): every stage holds, outputs stay stable, in_ready=0.
- Output register holds its value after the beat is consumed until overwritten; only out_valid drops.
- Simultaneous consume and accept: both occur in the same cycle; no loss, no duplication.
- Reset mid-flight: all in-flight beats are discarded; out_valid=0 in the cycle reset asserts; in_ready=1 from the first clock after release.
- Arithmetic is modulo 2^WIDTH. out_ovf uses two's-complement interpretation in both modes.

Decomposition:
- Package ks_adder_pkg holds:
  - pg_t: typedef {g, p} node;
  - function clog2;
  - derived constants NUM_LEVELS and LAT as package functions of WIDTH/LEVELS_PER_STAGE.
- Sub-module ks_prefix_level (params WIDTH, DIST): one combinational prefix level. Instantiated NUM_LEVELS times under generate; registers are inserted between groups in the top.

Test Plan:
- Default config, out_ready=1: A=0xFFFF, B=0x0001, sub=0, cin=0 -> after 3 cycles sum=0x0000, cout=1, zero=1, ovf=0.
- A=0x7FFF, B=0x0001, cin=1 -> sum=0x8001, cout=0, ovf=1. Sub mode, A=0x0005, B=0x0007 -> sum=0xFFFE, cout=0, ovf=0, zero=0.
- 100 back-to-back random beats with out_ready=1 -> one result per cycle, in order, matching the reference model; in_ready never drops.
- Backpressure: out_ready=0 for 5 cycles while streaming -> out_sum stable, in_ready=0, no beat lost or duplicated; resume delivers the remaining beats in order.
- Reset asserted with 3 beats in flight -> out_valid=0 immediately; no stale beat appears after release; first new beat emerges after LAT cycles.
- WIDTH=4, LEVELS_PER_STAGE=1 (LAT=3): exhaustive 256 A/B pairs x cin x sub -> all results match the model; sum/cout equal the 4-bit combinational adder for sub=0, cin=0.
